// File: rtl/mul_pkg.sv
// Shared types and widths for the radix-16 Booth multiplier job sequencer.
package mul_pkg;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int P_W   = 16;
  localparam int M3_W  = 10;
  localparam int M5_W  = 11;
  localparam int M7_W  = 11;
  localparam int IDX_W = 8;
  localparam int ACC_W = 24;

  typedef enum logic [1:0] {IDLE, PRECOMP, STREAM, DRAIN} sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } token_t;
endpackage

// File: rtl/mul_multiples.sv
// Odd-multiple registers (1X/3X/5X/7X) of the multiplicand, loaded once per job.
module mul_multiples
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [A_W-1:0]  a,
  output logic [A_W-1:0]  d1X,
  output logic [M3_W-1:0] d3X,
  output logic [M5_W-1:0] d5X,
  output logic [M7_W-1:0] d7X
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1X <= '0;
      d3X <= '0;
      d5X <= '0;
      d7X <= '0;
    end else if (load) begin
      d1X <= a;
      d3X <= {2'b0, a} + {1'b0, a, 1'b0};
      d5X <= {3'b0, a} + {1'b0, a, 2'b0};
      // 8A never underflows against A, so the 11-bit difference is exact
      d7X <= {a, 3'b0} - {3'b0, a};
    end
  end
endmodule

// File: rtl/mul_sched.sv
// Job sequencer for the radix-16 Booth multiplier: precomputes multiples, streams B, tags products.
// Optional running accumulator output oAcc when MUL_SCHED_ACC_EN is defined.
module mul_sched
  import mul_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic [A_W-1:0]   iA,
  input  logic [IDX_W-1:0] iLen,
  output logic             oBusy,
  input  logic             iBValid,
  input  logic [B_W-1:0]   iB,
  output logic             oBReady,
  output logic [B_W-1:0]   oMulDat,
  output logic [A_W-1:0]   oDat1X,
  output logic [M3_W-1:0]  oDat3X,
  output logic [M5_W-1:0]  oDat5X,
  output logic [M7_W-1:0]  oDat7X,
  input  logic [P_W-1:0]   iMulProd,
  output logic             oValid,
  output logic [P_W-1:0]   oProd,
  output logic [IDX_W-1:0] oIdx,
  output logic             oDone
`ifdef MUL_SCHED_ACC_EN
  , output logic signed [ACC_W-1:0] oAcc
`endif
);
  sched_state_e state, stateNxt;
  logic [A_W-1:0]   aQ;
  logic [IDX_W-1:0] lenQ, issueCnt;
  logic             accept, startAcc;
  // [0] rides with oMulDat; [1..MUL_LAT] track the multiplier's registers
  token_t [MUL_LAT:0] vldPipe;

  assign startAcc = (state == IDLE) && iStart;
  assign oBReady  = (state == STREAM);
  assign oBusy    = (state != IDLE);
  assign accept   = iBValid && oBReady;
  assign oValid   = vldPipe[MUL_LAT].valid;
  assign oIdx     = vldPipe[MUL_LAT].idx;
  assign oProd    = iMulProd;
  assign oDone    = (state == DRAIN) && vldPipe[MUL_LAT].valid && (vldPipe[MUL_LAT].idx == lenQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (startAcc) stateNxt = PRECOMP;
      PRECOMP: stateNxt = STREAM;
      STREAM:  if (accept && issueCnt == lenQ) stateNxt = DRAIN;
      DRAIN:   if (oDone) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aQ       <= '0;
      lenQ     <= '0;
      issueCnt <= '0;
      oMulDat  <= '0;
      vldPipe  <= '0;
    end else begin
      if (startAcc) begin
        aQ   <= iA;
        lenQ <= iLen;
      end
      if (state == PRECOMP) issueCnt <= '0;
      else if (accept)      issueCnt <= issueCnt + 1'b1;
      if (accept) oMulDat <= iB;
      vldPipe[0] <= '{valid: accept, idx: issueCnt};
      for (int i = 1; i <= MUL_LAT; i++) vldPipe[i] <= vldPipe[i-1];
    end
  end

  mul_multiples uMult (
    .clk  (clk),
    .rst  (rst),
    .load (state == PRECOMP),
    .a    (aQ),
    .d1X  (oDat1X),
    .d3X  (oDat3X),
    .d5X  (oDat5X),
    .d7X  (oDat7X)
  );

`ifdef MUL_SCHED_ACC_EN
  logic signed [ACC_W-1:0] accQ, prodExt;
  assign prodExt = {{(ACC_W-P_W){oProd[P_W-1]}}, oProd};
  // Current product folded in combinationally so the final sum is visible with oDone
  assign oAcc    = accQ + (oValid ? prodExt : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           accQ <= '0;
    else if (startAcc) accQ <= '0;
    else if (oValid)   accQ <= accQ + prodExt;
  end
`endif
endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched with a behavioural 3-stage multiplier model.
module tb_mul_sched;
  import mul_pkg::*;
  localparam int LAT = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic iStart = 1'b0, iBValid = 1'b0;
  logic [7:0] iA = '0, iLen = '0, iB = '0;
  logic oBusy, oBReady, oValid, oDone;
  logic [7:0] oMulDat, oDat1X, oIdx;
  logic [9:0] oDat3X;
  logic [10:0] oDat5X, oDat7X;
  logic [15:0] iMulProd, oProd;
`ifdef MUL_SCHED_ACC_EN
  logic signed [23:0] oAcc;
`endif

  mul_sched #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iA(iA), .iLen(iLen), .oBusy(oBusy),
    .iBValid(iBValid), .iB(iB), .oBReady(oBReady), .oMulDat(oMulDat),
    .oDat1X(oDat1X), .oDat3X(oDat3X), .oDat5X(oDat5X), .oDat7X(oDat7X),
    .iMulProd(iMulProd), .oValid(oValid), .oProd(oProd), .oIdx(oIdx), .oDone(oDone)
`ifdef MUL_SCHED_ACC_EN
    , .oAcc(oAcc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: signed B times unsigned A, LAT register stages
  logic [15:0] mp [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else begin
      mp[0] <= $signed({8'b0, oDat1X}) * $signed({{8{oMulDat[7]}}, oMulDat});
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign iMulProd = mp[LAT-1];

  typedef struct {
    logic [15:0] prod;
    int          idx;
    bit          done;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0, errors = 0;
  int accModel = 0;
  int curA, curLen, nextIdx;
  int dirB[4], dirG[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prodOf(input int a, input int b);
    int bs, p;
    bs = (b >= 128) ? b - 256 : b;
    p  = a * bs;
    return p[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (oValid) begin
        if (sb.size() == 0) chk("unexpected oValid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("oProd", oProd, e.prod);
          chk("oIdx", oIdx, e.idx);
          chk("oDone", oDone, e.done);
          chk("latency", cyc, e.due);
          accModel += int'($signed(e.prod));
`ifdef MUL_SCHED_ACC_EN
          if (e.done) chk("oAcc at done", int'(oAcc), accModel);
`endif
        end
      end else begin
        if (oDone) chk("oDone without oValid", 1, 0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          chk("late product", cyc, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic startJob(input int a, input int len);
    @(negedge clk);
    iStart = 1'b1; iA = 8'(a); iLen = 8'(len);
    curA = a; curLen = len; nextIdx = 0; accModel = 0;
    @(negedge clk);
    iStart = 1'b0;
    chk("precomp busy", oBusy, 1);
    chk("precomp ready", oBReady, 0);
`ifdef MUL_SCHED_ACC_EN
    chk("oAcc cleared", int'(oAcc), 0);
`endif
    @(negedge clk);
    chk("stream ready", oBReady, 1);
    chk("oDat1X", oDat1X, a);
    chk("oDat3X", oDat3X, 3 * a);
    chk("oDat5X", oDat5X, 5 * a);
    chk("oDat7X", oDat7X, 7 * a);
  endtask

  task automatic sendB(input int b, input int gaps);
    iBValid = 1'b0;
    repeat (gaps) @(negedge clk);
    iBValid = 1'b1; iB = 8'(b);
    chk("oBReady while streaming", oBReady, 1);
    @(posedge clk);
    #1;
    sb.push_back('{prod: prodOf(curA, b), idx: nextIdx, done: (nextIdx == curLen), due: cyc + LAT});
    nextIdx++;
    @(negedge clk);
    iBValid = 1'b0;
  endtask

  task automatic runJob(input int a, input int len, input int gapMax, input bit directed, input bit pulse);
    int n;
    startJob(a, len);
    for (int i = 0; i <= len; i++) begin
      if (pulse && i == 1) begin iStart = 1'b1; iA = ~8'(a); iLen = 8'd0; end
      sendB(directed ? dirB[i] : int'($urandom_range(0, 255)),
            directed ? dirG[i] : int'($urandom_range(0, gapMax)));
      iStart = 1'b0;
    end
    n = 0;
    while (sb.size() > 0 && n < LAT + 10) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("idle after done", oBusy, 0);
    chk("1X held", oDat1X, a);
    chk("oMulDat held", oMulDat, directed ? dirB[len] : int'(oMulDat));
    @(negedge clk);
    chk("still idle", oBusy, 0);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " oBusy"}, oBusy, 0);
    chk({tag, " oBReady"}, oBReady, 0);
    chk({tag, " oValid"}, oValid, 0);
    chk({tag, " oDone"}, oDone, 0);
    chk({tag, " oIdx"}, oIdx, 0);
    chk({tag, " oMulDat"}, oMulDat, 0);
    chk({tag, " oDat1X"}, oDat1X, 0);
    chk({tag, " oDat3X"}, oDat3X, 0);
    chk({tag, " oDat5X"}, oDat5X, 0);
    chk({tag, " oDat7X"}, oDat7X, 0);
`ifdef MUL_SCHED_ACC_EN
    chk({tag, " oAcc"}, int'(oAcc), 0);
`endif
  endtask

  initial begin
    @(negedge clk);
    chkReset("reset");
    rst = 1'b0;
    @(negedge clk);
    chkReset("post-reset");

    // single operand, fixed latency and done coincident with the only product
    dirB[0] = 3; dirG[0] = 0;
    runJob(5, 0, 0, 1'b1, 1'b0);

    // largest multiplicand
    dirB[0] = 1; dirG[0] = 0;
    runJob(255, 0, 0, 1'b1, 1'b0);

    // back-to-back stream
    dirB = '{1, 2, 3, 4}; dirG = '{0, 0, 0, 0};
    runJob(7, 3, 0, 1'b1, 1'b0);

    // negative B and a 2-cycle bubble
    dirB = '{253, 2, 0, 0}; dirG = '{0, 2, 0, 0};
    runJob(5, 1, 0, 1'b1, 1'b0);

    // accumulator case, also exercised in the default build
    dirB = '{1, 2, 3, 0}; dirG = '{0, 0, 0, 0};
    runJob(3, 2, 0, 1'b1, 1'b0);

    // iStart during STREAM must not disturb the job or queue another
    dirB = '{9, 200, 17, 128}; dirG = '{0, 1, 0, 0};
    runJob(9, 3, 0, 1'b1, 1'b1);

    repeat (8) runJob(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 3, 1'b0, 1'b0);
    runJob(int'($urandom_range(1, 255)), 255, 1, 1'b0, 1'b0);

    // reset one cycle after the second accept of a 4-operand job
    startJob(11, 3);
    sendB(1, 0);
    sendB(2, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chkReset("mid-job reset");
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no oValid after reset", oValid, 0);
      chk("no oDone after reset", oDone, 0);
    end
    chk("idle after reset", oBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
